// File: rtl/tc_pkg.sv
// ---------------------------------------------------------------------------
// tc_pkg -- shared constants and the combinational logic function for the
// test_circuit_core block.
//   PIPE_STAGES_DEFAULT : default number of register stages from input
//                         sampling to G
//   PIPE_STAGES_MAX     : largest legal stage count
//   tc_f                : f(a,b,c) = (a AND b) OR c
// ---------------------------------------------------------------------------
package tc_pkg;

    localparam int PIPE_STAGES_DEFAULT = 2;
    localparam int PIPE_STAGES_MAX     = 4;

    function automatic logic tc_f(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

endpackage

// File: rtl/tc_pipe_reg.sv
// ---------------------------------------------------------------------------
// tc_pipe_reg -- 1-bit shift register of parameterised depth with an
// asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear of every stage
//   d     : serial input
//   q     : output of the last stage (DEPTH = 0 degenerates to a wire)
// ---------------------------------------------------------------------------
module tc_pipe_reg #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [DEPTH-1:0] sr_q;
            logic [DEPTH-1:0] sr_d;

            always_comb begin
                sr_d    = '0;
                sr_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign q = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/test_circuit_core.sv
// ---------------------------------------------------------------------------
// test_circuit_core -- registered G = (A AND B) OR C with a configurable
// pipeline depth.
//   PIPE_STAGES : register stages from the A/B/C sampling edge to G (1..4)
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset, clears the whole pipeline
//   A, B, C     : logic operands, sampled every rising edge (no handshake)
//   G           : registered result, driven straight from a flop
// Inputs sampled at edge k appear on G right after edge k+PIPE_STAGES-1.
// ---------------------------------------------------------------------------
module test_circuit_core
    import tc_pkg::*;
#(
    parameter int PIPE_STAGES = PIPE_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic G
);

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_bad_param
            $error("test_circuit_core: PIPE_STAGES must be in 1..%0d", PIPE_STAGES_MAX);
        end
    endgenerate

    logic f_res;

    generate
        if (PIPE_STAGES == 1) begin : g_single
            // With a single stage there is no register after the sampling
            // flop, so the sampling flop stores f itself; this keeps G
            // flop-driven with the required one-edge latency.
            logic f_q;
            logic f_d;

            always_comb begin
                f_d = tc_f(A, B, C);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    f_q <= 1'b0;
                end else begin
                    f_q <= f_d;
                end
            end

            assign f_res = f_q;
        end else begin : g_multi
            logic [2:0] abc_q;
            logic [2:0] abc_d;

            always_comb begin
                abc_d = {A, B, C};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    abc_q <= 3'b000;
                end else begin
                    abc_q <= abc_d;
                end
            end

            assign f_res = tc_f(abc_q[2], abc_q[1], abc_q[0]);
        end
    endgenerate

    tc_pipe_reg #(
        .DEPTH (PIPE_STAGES - 1)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (f_res),
        .q     (G)
    );

endmodule

// File: tb/tb_test_circuit_core.sv
// ---------------------------------------------------------------------------
// tb_test_circuit_core -- drives three instances (PIPE_STAGES = 1, 2, 4) with
// identical stimulus and checks every G against a history-queue model, plus
// literal expectations for reset, the truth table, toggling and reset
// mid-stream.
// ---------------------------------------------------------------------------
module tb_test_circuit_core;

    logic clk;
    logic rst_n;
    logic A, B, C;
    logic g1, g2, g4;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    logic [7:0] tt;          // truth table, bit index = {A,B,C}
    logic       hist[$];     // f of every input sampled since reset

    test_circuit_core #(.PIPE_STAGES(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .G(g1));
    test_circuit_core #(.PIPE_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .G(g2));
    test_circuit_core #(.PIPE_STAGES(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .G(g4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: every sampling edge records f; a P-stage pipe shows the
    // sample taken P-1 edges ago, or 0 if that many edges have not happened
    // since reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist.delete();
        else        hist.push_back(tt[{A, B, C}]);
    end

    function automatic logic exp_g(int p);
        int n;
        n = hist.size();
        if (n >= p) return hist[n-p];
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_p1", g1, exp_g(1));
            chk("model_p2", g2, exp_g(2));
            chk("model_p4", g4, exp_g(4));
        end
    end

    task automatic drive(input logic [2:0] v);
        {A, B, C} = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        tt    = 8'hEA;
        rst_n = 1'b1;
        drive(3'b111);
        #1 rst_n = 1'b0;
        #1 checking = 1;

        // Reset held for three cycles with ABC=111.
        repeat (3) begin
            tick();
            chk("rst_hold_p2", g2, 1'b0);
            chk("rst_hold_p1", g1, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        chk("rel_p1_edge1", g1, 1'b1);
        chk("rel_p2_edge1", g2, 1'b0);
        tick();
        chk("rel_p2_edge2", g2, 1'b1);
        chk("rel_p4_edge2", g4, 1'b0);

        // Exhaustive truth table, one vector per cycle.
        for (int v = 0; v < 8; v++) begin
            drive(3'(v));
            tick();
            chk("exh_p1", g1, tt[v]);
            if (v > 0) chk("exh_p2", g2, tt[v-1]);
            if (v > 2) chk("exh_p4", g4, tt[v-3]);
        end
        drive(3'b000);
        tick();
        chk("exh_p2_last", g2, 1'b1);

        // Toggle stream 110 / 000.
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 3'b110 : 3'b000);
            tick();
            if (i > 0) chk("toggle_p2", g2, ((i - 1) % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Reset mid-stream: 001 for five cycles, short low pulse between edges.
        drive(3'b001);
        repeat (5) tick();
        chk("pre_rst_p4", g4, 1'b1);
        #1 rst_n = 1'b0;          // posedge+3
        #1;
        chk("async_p1", g1, 1'b0);
        chk("async_p2", g2, 1'b0);
        chk("async_p4", g4, 1'b0);
        #2 rst_n = 1'b1;          // released after the negedge, before next posedge
        drive(3'b000);
        tick();
        chk("post_rst_p2", g2, 1'b0);
        chk("post_rst_p4", g4, 1'b0);
        drive(3'b001);
        repeat (3) tick();
        chk("post_rst_p4_old", g4, 1'b0);
        tick();
        chk("post_rst_p4_new", g4, 1'b1);

        // Random vectors against the model.
        for (int i = 0; i < 1000; i++) begin
            drive(3'($urandom_range(0, 7)));
            tick();
        end

        tick();
        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
